// File: rtl/gpio_tie_pkg.sv
// Shared types and sizing helpers for the GPIO tie-level array.
package gpio_tie_pkg;

   localparam int GPIO_MAX = 64;

   typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} tie_state_e;

   // Hold counter must be able to hold HOLD_CYCLES itself; never zero width.
   function automatic int cnt_width(input int hold);
      int w;
      w = $clog2(hold + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gpio_tie_shift.sv
// Serial-in / parallel-out level shift register. Optional tail tap when
// GPIO_TIE_READBACK_EN is defined, for daisy-chaining instances.
module gpio_tie_shift
   import gpio_tie_pkg::*;
#(
   parameter int                  NUM_GPIO  = 38,
   parameter logic [NUM_GPIO-1:0] RESET_VAL = {NUM_GPIO{1'b1}}
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic                data_i,
`ifdef GPIO_TIE_READBACK_EN
   output logic                tap_o,
`endif
   output logic [NUM_GPIO-1:0] par_o
);

   logic [NUM_GPIO-1:0] shift_q, shift_d;

   generate
      if (NUM_GPIO == 1) begin : g_one
         assign shift_d = data_i;
      end else begin : g_many
         assign shift_d = {shift_q[NUM_GPIO-2:0], data_i};
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i)        shift_q <= RESET_VAL;
      else if (valid_i) shift_q <= shift_d;
   end

   assign par_o = shift_q;

`ifdef GPIO_TIE_READBACK_EN
   assign tap_o = shift_q[NUM_GPIO-1];
`endif

endmodule

// File: rtl/gpio_tie_array.sv
// Multi-channel tie-high/low generator: serial load, commit, post-reset hold.
// Build option: GPIO_TIE_READBACK_EN adds the ser_data_out chain output.
module gpio_tie_array
   import gpio_tie_pkg::*;
#(
   parameter int                  NUM_GPIO      = 38,
   parameter logic [NUM_GPIO-1:0] DEFAULT_LEVEL = {NUM_GPIO{1'b1}},
   parameter int                  HOLD_CYCLES   = 16
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                ser_valid,
   input  logic                ser_data,
   input  logic                ser_commit,
`ifdef GPIO_TIE_READBACK_EN
   output logic                ser_data_out,
`endif
   output logic                busy,
   output logic                commit_done,
   output logic [NUM_GPIO-1:0] gpio_logic1,
   output logic [NUM_GPIO-1:0] gpio_logic0
);

   localparam int              CW     = cnt_width(HOLD_CYCLES);
   localparam logic [CW-1:0]   LAST   = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam tie_state_e      RST_ST = (HOLD_CYCLES > 0) ? ST_HOLD : ST_RUN;

   tie_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pend_q, pend_d;
   logic                done_q, done_d;
   logic [NUM_GPIO-1:0] act_q, act_d;
   logic [NUM_GPIO-1:0] shift;

   gpio_tie_shift #(
      .NUM_GPIO  (NUM_GPIO),
      .RESET_VAL (DEFAULT_LEVEL)
   ) u_shift (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .valid_i (ser_valid),
      .data_i  (ser_data),
`ifdef GPIO_TIE_READBACK_EN
      .tap_o   (ser_data_out),
`endif
      .par_o   (shift)
   );

   // Commits use the pre-shift register value, so a same-cycle strobe lands after.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      act_d   = act_q;
      done_d  = 1'b0;
      case (state_q)
         ST_HOLD: begin
            cnt_d  = cnt_q + 1'b1;
            pend_d = pend_q | ser_commit;
            if (cnt_q == LAST) begin
               state_d = ST_RUN;
               pend_d  = 1'b0;
               if (pend_q || ser_commit) begin
                  act_d  = shift;
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (ser_commit) begin
               act_d  = shift;
               done_d = 1'b1;
            end
         end
         default: state_d = RST_ST;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         act_q   <= DEFAULT_LEVEL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         act_q   <= act_d;
      end
   end

   assign busy        = (state_q == ST_HOLD);
   assign commit_done = done_q;
   assign gpio_logic1 = act_q;
   assign gpio_logic0 = ~act_q;

endmodule

// File: tb/tb_gpio_tie_array.sv
// Directed self-checking bench: HOLD_CYCLES=4 and HOLD_CYCLES=0 instances.
module tb_gpio_tie_array;

   logic       clk = 1'b0;
   logic       rst, valid, data, commit;
   logic       busy, done;
   logic [7:0] g1, g0;
   logic       r0_rst, r0_valid, r0_data, r0_commit;
   logic       r0_busy, r0_done;
   logic [7:0] r0_g1, r0_g0;
`ifdef GPIO_TIE_READBACK_EN
   logic       tap, r0_tap;
`endif

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   gpio_tie_array #(.NUM_GPIO(8), .DEFAULT_LEVEL(8'hA5), .HOLD_CYCLES(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .ser_valid(valid), .ser_data(data),
      .ser_commit(commit),
`ifdef GPIO_TIE_READBACK_EN
      .ser_data_out(tap),
`endif
      .busy(busy), .commit_done(done), .gpio_logic1(g1), .gpio_logic0(g0));

   gpio_tie_array #(.NUM_GPIO(8), .DEFAULT_LEVEL(8'h3C), .HOLD_CYCLES(0)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(r0_rst), .ser_valid(r0_valid), .ser_data(r0_data),
      .ser_commit(r0_commit),
`ifdef GPIO_TIE_READBACK_EN
      .ser_data_out(r0_tap),
`endif
      .busy(r0_busy), .commit_done(r0_done), .gpio_logic1(r0_g1), .gpio_logic0(r0_g0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; data = 1'b0; commit = 1'b0;
      tick(); tick();
      rst = 1'b0;
      vec++; if (g1 !== 8'hA5) begin errs++; $display("FAIL reset_g1 got %h exp a5", g1); end
      vec++; if (g0 !== 8'h5A) begin errs++; $display("FAIL reset_g0 got %h exp 5a", g0); end
      vec++; if (busy !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL reset_flags busy=%b done=%b exp 1 0", busy, done); end
`ifdef GPIO_TIE_READBACK_EN
      vec++; if (tap !== 1'b1) begin errs++; $display("FAIL reset_tap got %b exp 1", tap); end
`endif
      for (int i = 0; i < 4; i++) begin
         tick();
         vec++;
         if (busy !== (i < 3)) begin errs++; $display("FAIL hold_busy edge %0d got %b exp %b", i, busy, (i < 3)); end
      end
   endtask

   task automatic test_run_commit();
      logic [7:0] bits;
      bits = 8'b1000_0001;
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; data = bits[7-i];
         tick();
      end
      valid = 1'b0;
      vec++; if (g1 !== 8'hA5) begin errs++; $display("FAIL run_precommit got %h exp a5", g1); end
`ifdef GPIO_TIE_READBACK_EN
      vec++; if (tap !== 1'b1) begin errs++; $display("FAIL run_tap got %b exp 1", tap); end
`endif
      commit = 1'b1; tick(); commit = 1'b0;
      vec++; if (g1 !== 8'h81 || g0 !== 8'h7E) begin errs++; $display("FAIL run_commit got %h/%h exp 81/7e", g1, g0); end
      vec++; if (done !== 1'b1) begin errs++; $display("FAIL run_done got %b exp 1", done); end
      tick();
      vec++; if (done !== 1'b0 || g1 !== 8'h81) begin errs++; $display("FAIL run_done_clr done=%b g1=%h exp 0 81", done, g1); end
   endtask

   task automatic test_hold_commit();
      int pulses;
      rst = 1'b1; tick(); rst = 1'b0;
      // ones shifted in every hold cycle; two commits coalesce into one
      valid = 1'b1; data = 1'b1; commit = 1'b1;
      tick();
      vec++; if (g1 !== 8'hA5 || done !== 1'b0) begin errs++; $display("FAIL hold_e0 g1=%h done=%b exp a5 0", g1, done); end
      tick(); commit = 1'b0;
      vec++; if (g1 !== 8'hA5 || done !== 1'b0) begin errs++; $display("FAIL hold_e1 g1=%h done=%b exp a5 0", g1, done); end
      tick();
      vec++; if (g1 !== 8'hA5 || busy !== 1'b1) begin errs++; $display("FAIL hold_e2 g1=%h busy=%b exp a5 1", g1, busy); end
      tick(); valid = 1'b0;
      vec++; if (g1 !== 8'h2F || g0 !== 8'hD0) begin errs++; $display("FAIL hold_release got %h/%h exp 2f/d0", g1, g0); end
      vec++; if (busy !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL hold_release_flags busy=%b done=%b exp 0 1", busy, done); end
      pulses = int'(done);
      for (int i = 0; i < 4; i++) begin tick(); pulses += int'(done); end
      vec++; if (pulses !== 1) begin errs++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bits;
      bits = 8'h01;
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; data = bits[7-i];
         tick();
      end
      valid = 1'b1; data = 1'b0; commit = 1'b1;
      tick();
      valid = 1'b0;
      vec++; if (g1 !== 8'h01 || done !== 1'b1) begin errs++; $display("FAIL same_cycle g1=%h done=%b exp 01 1", g1, done); end
      tick(); commit = 1'b0;
      vec++; if (g1 !== 8'h02 || done !== 1'b1) begin errs++; $display("FAIL b2b g1=%h done=%b exp 02 1", g1, done); end
`ifdef GPIO_TIE_READBACK_EN
      vec++; if (tap !== 1'b0) begin errs++; $display("FAIL b2b_tap got %b exp 0", tap); end
`endif
      tick();
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL b2b_clr got %b exp 0", done); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; tick(); rst = 1'b0;
      commit = 1'b1; tick(); tick(); commit = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      vec++; if (g1 !== 8'hA5 || busy !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL rst_hold g1=%h busy=%b done=%b exp a5 1 0", g1, busy, done); end
      for (int i = 0; i < 4; i++) begin
         tick();
         vec++;
         if (busy !== (i < 3) || done !== 1'b0) begin errs++; $display("FAIL rst_hold_len edge %0d busy=%b done=%b exp %b 0", i, busy, done, (i < 3)); end
      end
      for (int i = 0; i < 4; i++) begin valid = 1'b1; data = 1'b0; tick(); end
      valid = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
      vec++; if (g1 !== 8'h50) begin errs++; $display("FAIL pre_rst_commit got %h exp 50", g1); end
      valid = 1'b1; data = 1'b1; tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0; valid = 1'b0;
      vec++; if (g1 !== 8'hA5 || g0 !== 8'h5A || busy !== 1'b1) begin errs++; $display("FAIL rst_shift g=%h/%h busy=%b exp a5/5a 1", g1, g0, busy); end
      for (int i = 0; i < 4; i++) tick();
      commit = 1'b1; tick(); commit = 1'b0;
      vec++; if (g1 !== 8'hA5 || done !== 1'b1) begin errs++; $display("FAIL rst_shift_clr g1=%h done=%b exp a5 1", g1, done); end
   endtask

   task automatic test_hold0();
      r0_rst = 1'b1; r0_valid = 1'b0; r0_data = 1'b0; r0_commit = 1'b0;
      tick();
      vec++; if (r0_busy !== 1'b0 || r0_g1 !== 8'h3C || r0_g0 !== 8'hC3) begin errs++; $display("FAIL h0_reset busy=%b g=%h/%h exp 0 3c/c3", r0_busy, r0_g1, r0_g0); end
      r0_rst = 1'b0; r0_commit = 1'b1; r0_valid = 1'b1; r0_data = 1'b1;
      tick();
      r0_commit = 1'b0; r0_valid = 1'b0;
      vec++; if (r0_done !== 1'b1 || r0_g1 !== 8'h3C) begin errs++; $display("FAIL h0_edge0 done=%b g1=%h exp 1 3c", r0_done, r0_g1); end
      r0_commit = 1'b1; tick(); r0_commit = 1'b0;
      vec++; if (r0_g1 !== 8'h79 || r0_g0 !== 8'h86 || r0_busy !== 1'b0) begin errs++; $display("FAIL h0_commit g=%h/%h busy=%b exp 79/86 0", r0_g1, r0_g0, r0_busy); end
   endtask

   initial begin
      r0_rst = 1'b1; r0_valid = 1'b0; r0_data = 1'b0; r0_commit = 1'b0;
      test_reset();
      test_run_commit();
      test_hold_commit();
      test_back_to_back();
      test_reset_mid();
      test_hold0();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
